sa_ax_arbiter: RTL and testbench
================================

Name: sa_ax_arbiter

Overview:
- Slave-side arbitration for one AXI write/read address (Ax) channel in the interconnect.
- Takes per-master Ax requests from the master dispatchers and grants one at a time using round-robin.
- Forwards the granted request through a registered output stage to the slave port.
- Records grant order (master index, AxLEN) in an internal order FIFO, so the slave's data/response routing knows which master owns each burst; this also bounds outstanding transactions.

Parameters:
MST_AMT, 2, number of requesting masters
MST_ID_W, $clog2(MST_AMT) (min 1), width of master index
OUTSTANDING_AMT, 8, order FIFO depth (max outstanding bursts; power of 2)
OUTST_CTN_W, $clog2(OUTSTANDING_AMT)+1, outstanding counter width
ADDR_WIDTH, 32, address width
TRANS_MST_ID_W, 5, master transaction ID width
TRANS_SLV_ID_W, TRANS_MST_ID_W+MST_ID_W, slave-side ID width
TRANS_BURST_W, 2, AxBURST width
TRANS_DATA_LEN_W, 3, AxLEN width
TRANS_DATA_SIZE_W, 3, AxSIZE width

Ports:
ACLK_i  in  1  clock
ARESET_i  in  1  reset, asynchronous, active-high
m_AxID_i  in  TRANS_MST_ID_W*MST_AMT  per-master AxID, packed; master k at slice k
m_AxADDR_i  in  ADDR_WIDTH*MST_AMT  per-master address
m_AxBURST_i  in  TRANS_BURST_W*MST_AMT  per-master burst type
m_AxLEN_i  in  TRANS_DATA_LEN_W*MST_AMT  per-master burst length
m_AxSIZE_i  in  TRANS_DATA_SIZE_W*MST_AMT  per-master beat size
m_AxVALID_i  in  MST_AMT  per-master request valid
m_AxREADY_o  out  MST_AMT  per-master accept (one-hot or zero)
s_AxID_o  out  TRANS_SLV_ID_W  {master index, AxID}
s_AxADDR_o  out  ADDR_WIDTH  granted address
s_AxBURST_o  out  TRANS_BURST_W  granted burst type
s_AxLEN_o  out  TRANS_DATA_LEN_W  granted length
s_AxSIZE_o  out  TRANS_DATA_SIZE_W  granted size
s_AxVALID_o  out  1  slave request valid
s_AxREADY_i  in  1  slave accept
ord_mst_id_o  out  MST_ID_W  owner master of oldest outstanding burst
ord_AxLEN_o  out  TRANS_DATA_LEN_W  length of oldest outstanding burst
ord_valid_o  out  1  order FIFO not empty
ord_ready_i  in  1  pop oldest entry (data channel asserts at last beat/response)
outst_ctn_o  out  OUTST_CTN_W  current order FIFO occupancy

Behaviour:
- Reset (async assert, sync release): state IDLE, output register 0, s_AxVALID_o=0, m_AxREADY_o=0, rr pointer=0, FIFO empty, outst_ctn_o=0, ord_valid_o=0. Reset mid-transaction drops all pending and outstanding state.
- FSM, two states:
  - IDLE: s_AxVALID_o=0.
  - SEND: s_AxVALID_o=1; output register stable until handshake.
- can_accept = (state==IDLE | (SEND & s_AxREADY_i)) & |m_AxVALID_i & (outst_ctn_o < OUTSTANDING_AMT). The full check uses the registered count; a same-cycle pop does not free space.
- Grant: combinational round-robin. Search starts at rr pointer, wraps modulo MST_AMT, picks the first asserted m_AxVALID_i. m_AxREADY_o[grant]=can_accept, all others 0.
- On accept (cycle T):
  - Capture granted fields into the output register; s_AxID_o = {grant, m_AxID}.
  - Push {grant, AxLEN} into the order FIFO.
  - rr pointer <= grant+1 (wraps MST_AMT-1 -> 0).
  - State goes to SEND.
  - s_AxVALID_o=1 from T+1: latency 1 cycle.
- In SEND with s_AxREADY_i:
  - If can_accept, load the next request the same cycle: back-to-back, 1 request/cycle.
  - Otherwise go to IDLE.
- In SEND without s_AxREADY_i: hold; m_AxREADY_o=0.
- Order FIFO: first-word-fall-through; ord_* reflect the head.
  - Pop on ord_valid_o & ord_ready_i; ord_ready_i ignored when empty.
  - Simultaneous push and pop: count unchanged, both take effect.
- outst_ctn_o: +1 on push, -1 on pop, net 0 on both; never exceeds OUTSTANDING_AMT.
- Master-side rule: masters hold request fields stable while VALID is high and READY is low. The block does not re-sample an unaccepted request.

Optional Feature:
- Macro SA_AX_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest master index wins; rr pointer logic removed.
- Undefined: round-robin as described above.

Test Plan:
- Single request: m_AxVALID_i=2'b01, AxID=5'h3, ADDR=32'h4000_0010, LEN=3, s_AxREADY_i=1 -> m_AxREADY_o=2'b01 at T; s_AxVALID_o=1, s_AxID_o=6'h03 at T+1; outst_ctn_o=1; ord_mst_id_o=0, ord_AxLEN_o=3.
- Round-robin: both masters valid continuously, s_AxREADY_i=1 -> grants alternate 0,1,0,1; s_AxVALID_o high every cycle after the first; s_AxID_o MSB toggles.
- Slave backpressure: s_AxREADY_i=0 for 4 cycles -> s_Ax* stable; m_AxREADY_o=0 throughout; the next grant occurs in the handshake cycle.
- Full: 8 accepts with no pops -> outst_ctn_o=8 and m_AxREADY_o=0. Pop in the same cycle as a new request -> request not accepted that cycle, accepted next cycle, count back to 8.
- Simultaneous push/pop at count=3 -> count stays 3; FIFO order preserved (pops return grants in accept order).
- Async reset asserted in SEND with count=5 -> s_AxVALID_o, outst_ctn_o and ord_valid_o go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sa_ax_arbiter.sv
// Slave-side Ax channel arbiter: round-robin grant, registered output stage and grant-order FIFO.
// Define SA_AX_FIXED_PRIORITY_EN for fixed priority (lowest master index wins) instead of round-robin.
module sa_ax_arbiter #(
  parameter int MST_AMT           = 2,
  parameter int MST_ID_W          = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3
) (
  input  logic                                   ACLK_i,
  input  logic                                   ARESET_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]      m_AxID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]          m_AxADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]       m_AxBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]    m_AxLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]   m_AxSIZE_i,
  input  logic [MST_AMT-1:0]                     m_AxVALID_i,
  output logic [MST_AMT-1:0]                     m_AxREADY_o,
  output logic [TRANS_SLV_ID_W-1:0]              s_AxID_o,
  output logic [ADDR_WIDTH-1:0]                  s_AxADDR_o,
  output logic [TRANS_BURST_W-1:0]               s_AxBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]            s_AxLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]           s_AxSIZE_o,
  output logic                                   s_AxVALID_o,
  input  logic                                   s_AxREADY_i,
  output logic [MST_ID_W-1:0]                    ord_mst_id_o,
  output logic [TRANS_DATA_LEN_W-1:0]            ord_AxLEN_o,
  output logic                                   ord_valid_o,
  input  logic                                   ord_ready_i,
  output logic [OUTST_CTN_W-1:0]                 outst_ctn_o
);

  localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
  localparam int ORD_W = MST_ID_W + TRANS_DATA_LEN_W;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                        state_q, state_d;
  logic [MST_ID_W-1:0]           grant;
  logic                          can_accept;
  logic                          push, pop;

  logic [TRANS_MST_ID_W-1:0]     sel_id;
  logic [ADDR_WIDTH-1:0]         sel_addr;
  logic [TRANS_BURST_W-1:0]      sel_burst;
  logic [TRANS_DATA_LEN_W-1:0]   sel_len;
  logic [TRANS_DATA_SIZE_W-1:0]  sel_size;

  logic [TRANS_SLV_ID_W-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [TRANS_BURST_W-1:0]      burst_q, burst_d;
  logic [TRANS_DATA_LEN_W-1:0]   len_q, len_d;
  logic [TRANS_DATA_SIZE_W-1:0]  size_q, size_d;

  logic [ORD_W-1:0]              fifo_mem_q [OUTSTANDING_AMT];
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [OUTST_CTN_W-1:0]        cnt_q, cnt_d;

`ifdef SA_AX_FIXED_PRIORITY_EN
  always_comb begin
    grant = '0;
    for (int i = MST_AMT - 1; i >= 0; i--) begin
      if (m_AxVALID_i[i]) grant = MST_ID_W'(i);
    end
  end
`else
  logic [MST_ID_W-1:0] rr_q, rr_d;
  logic [MST_ID_W-1:0] grant_hi, grant_lo;
  logic                found_hi;

  // Prefer the lowest requester at or above the pointer; otherwise wrap to the lowest overall.
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    found_hi = 1'b0;
    for (int i = MST_AMT - 1; i >= 0; i--) begin
      if (m_AxVALID_i[i]) grant_lo = MST_ID_W'(i);
      if (m_AxVALID_i[i] && (MST_ID_W'(i) >= rr_q)) begin
        grant_hi = MST_ID_W'(i);
        found_hi = 1'b1;
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  always_comb begin
    rr_d = rr_q;
    if (can_accept) begin
      rr_d = (grant == MST_ID_W'(MST_AMT - 1)) ? '0 : grant + MST_ID_W'(1);
    end
  end

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) rr_q <= '0;
    else          rr_q <= rr_d;
  end
`endif

  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_burst = '0;
    sel_len   = '0;
    sel_size  = '0;
    for (int i = 0; i < MST_AMT; i++) begin
      if (grant == MST_ID_W'(i)) begin
        sel_id    = m_AxID_i[i*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        sel_addr  = m_AxADDR_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_burst = m_AxBURST_i[i*TRANS_BURST_W +: TRANS_BURST_W];
        sel_len   = m_AxLEN_i[i*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        sel_size  = m_AxSIZE_i[i*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      end
    end
  end

  // Full check uses the registered count, so a pop in the same cycle never frees a slot early.
  always_comb begin
    can_accept = ((state_q == IDLE) || s_AxREADY_i) && (|m_AxVALID_i) &&
                 (cnt_q < OUTST_CTN_W'(OUTSTANDING_AMT));
    m_AxREADY_o = '0;
    for (int i = 0; i < MST_AMT; i++) begin
      m_AxREADY_o[i] = can_accept && (grant == MST_ID_W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    len_d   = len_q;
    size_d  = size_q;
    if (can_accept) begin
      state_d = SEND;
      id_d    = {grant, sel_id};
      addr_d  = sel_addr;
      burst_d = sel_burst;
      len_d   = sel_len;
      size_d  = sel_size;
    end else if ((state_q == SEND) && s_AxREADY_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      len_q   <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      len_q   <= len_d;
      size_q  <= size_d;
    end
  end

  assign push = can_accept;
  assign pop  = (cnt_q != '0) && ord_ready_i;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + OUTST_CTN_W'(1);
    else if (!push && pop) cnt_d = cnt_q - OUTST_CTN_W'(1);
  end

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge ACLK_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {grant, sel_len};
  end

  assign {ord_mst_id_o, ord_AxLEN_o} = fifo_mem_q[rd_ptr_q];
  assign ord_valid_o = (cnt_q != '0);
  assign outst_ctn_o = cnt_q;

  assign s_AxID_o    = id_q;
  assign s_AxADDR_o  = addr_q;
  assign s_AxBURST_o = burst_q;
  assign s_AxLEN_o   = len_q;
  assign s_AxSIZE_o  = size_q;
  assign s_AxVALID_o = (state_q == SEND);

endmodule

// File: tb/tb_sa_ax_arbiter.sv
// Self-checking bench for sa_ax_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_sa_ax_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [4:0]  m_id    [2];
  logic [31:0] m_addr  [2];
  logic [1:0]  m_burst [2];
  logic [2:0]  m_len   [2];
  logic [2:0]  m_size  [2];
  logic [1:0]  m_valid = 2'b00;
  logic        s_ready = 1'b0;
  logic        ord_ready = 1'b0;

  logic [9:0]  m_AxID_i;
  logic [63:0] m_AxADDR_i;
  logic [3:0]  m_AxBURST_i;
  logic [5:0]  m_AxLEN_i;
  logic [5:0]  m_AxSIZE_i;
  logic [1:0]  m_AxREADY_o;
  logic [5:0]  s_AxID_o;
  logic [31:0] s_AxADDR_o;
  logic [1:0]  s_AxBURST_o;
  logic [2:0]  s_AxLEN_o;
  logic [2:0]  s_AxSIZE_o;
  logic        s_AxVALID_o;
  logic [0:0]  ord_mst_id_o;
  logic [2:0]  ord_AxLEN_o;
  logic        ord_valid_o;
  logic [3:0]  outst_ctn_o;

  int checks = 0;
  int failures = 0;

  assign m_AxID_i    = {m_id[1], m_id[0]};
  assign m_AxADDR_i  = {m_addr[1], m_addr[0]};
  assign m_AxBURST_i = {m_burst[1], m_burst[0]};
  assign m_AxLEN_i   = {m_len[1], m_len[0]};
  assign m_AxSIZE_i  = {m_size[1], m_size[0]};

  sa_ax_arbiter dut (
    .ACLK_i(ACLK), .ARESET_i(ARESET),
    .m_AxID_i(m_AxID_i), .m_AxADDR_i(m_AxADDR_i), .m_AxBURST_i(m_AxBURST_i),
    .m_AxLEN_i(m_AxLEN_i), .m_AxSIZE_i(m_AxSIZE_i), .m_AxVALID_i(m_valid),
    .m_AxREADY_o(m_AxREADY_o),
    .s_AxID_o(s_AxID_o), .s_AxADDR_o(s_AxADDR_o), .s_AxBURST_o(s_AxBURST_o),
    .s_AxLEN_o(s_AxLEN_o), .s_AxSIZE_o(s_AxSIZE_o), .s_AxVALID_o(s_AxVALID_o),
    .s_AxREADY_i(s_ready),
    .ord_mst_id_o(ord_mst_id_o), .ord_AxLEN_o(ord_AxLEN_o), .ord_valid_o(ord_valid_o),
    .ord_ready_i(ord_ready), .outst_ctn_o(outst_ctn_o)
  );

  always #5 ACLK = ~ACLK;

  // Reference model: slave-side pending request, rotating start index and a queue of grants.
  bit          e_busy;
  logic [5:0]  e_id;
  logic [31:0] e_addr;
  logic [1:0]  e_burst;
  logic [2:0]  e_len;
  logic [2:0]  e_size;
  int          e_rr;
  logic [3:0]  ord_q [$];
  bit          e_can;
  int          e_g;
  logic [1:0]  e_ready;
  int          last_acc;

  task automatic model_reset();
    e_busy = 0; e_id = '0; e_addr = '0; e_burst = '0; e_len = '0; e_size = '0;
    e_rr = 0; ord_q.delete(); e_can = 0; e_g = -1; e_ready = 2'b00; last_acc = -1;
  endtask

  task automatic model_eval();
    e_g = -1;
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = (e_rr + k) % 2;
      if (e_g < 0 && m_valid[idx]) e_g = idx;
    end
    e_can = (!e_busy || s_ready) && (e_g >= 0) && (ord_q.size() < 8);
    e_ready = e_can ? 2'(1 << e_g) : 2'b00;
  endtask

  task automatic model_apply();
    last_acc = -1;
    if (ord_q.size() > 0 && ord_ready) void'(ord_q.pop_front());
    if (e_can) begin
      ord_q.push_back({e_g[0], m_len[e_g]});
      e_id = {e_g[0], m_id[e_g]};
      e_addr = m_addr[e_g]; e_burst = m_burst[e_g]; e_len = m_len[e_g]; e_size = m_size[e_g];
      e_busy = 1;
`ifdef SA_AX_FIXED_PRIORITY_EN
      e_rr = 0;
`else
      e_rr = (e_g + 1) % 2;
`endif
      last_acc = e_g;
    end else if (e_busy && s_ready) begin
      e_busy = 0;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge ACLK);
    model_apply();
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    m_valid = 2'b00; s_ready = 1'b0; ord_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_id[k] = '0; m_addr[k] = '0; m_burst[k] = '0; m_len[k] = '0; m_size[k] = '0;
    end
    model_reset();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    m_valid = 2'b00;
    #1;
    checks++; if (s_AxVALID_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_svalid got=%b exp=0", s_AxVALID_o); end
    checks++; if (m_AxREADY_o !== 2'b00) begin failures++; $display("[TB] FAIL reset_mready got=%b exp=00", m_AxREADY_o); end
    checks++; if (outst_ctn_o !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", outst_ctn_o); end
    checks++; if (ord_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ordvalid got=%b exp=0", ord_valid_o); end
    checks++; if ({s_AxID_o, s_AxADDR_o} !== 38'd0) begin failures++; $display("[TB] FAIL reset_outreg got=%h exp=0", {s_AxID_o, s_AxADDR_o}); end
    do_reset();
    #1;
    checks++; if ({s_AxVALID_o, ord_valid_o, outst_ctn_o} !== 6'd0) begin failures++; $display("[TB] FAIL reset_release got=%b exp=0", {s_AxVALID_o, ord_valid_o, outst_ctn_o}); end
  endtask

  task automatic test_single();
    do_reset();
    m_valid = 2'b01; m_id[0] = 5'h3; m_addr[0] = 32'h4000_0010; m_len[0] = 3'd3;
    m_burst[0] = 2'd1; m_size[0] = 3'd2; s_ready = 1'b1;
    #1;
    checks++; if (m_AxREADY_o !== 2'b01) begin failures++; $display("[TB] FAIL single_mready got=%b exp=01", m_AxREADY_o); end
    checks++; if (s_AxVALID_o !== 1'b0) begin failures++; $display("[TB] FAIL single_latency got=%b exp=0", s_AxVALID_o); end
    tick();
    m_valid = 2'b00;
    #1;
    checks++; if (s_AxVALID_o !== 1'b1) begin failures++; $display("[TB] FAIL single_svalid got=%b exp=1", s_AxVALID_o); end
    checks++; if (s_AxID_o !== 6'h03) begin failures++; $display("[TB] FAIL single_sid got=%h exp=03", s_AxID_o); end
    checks++; if ({s_AxADDR_o, s_AxLEN_o, s_AxBURST_o, s_AxSIZE_o} !== {32'h4000_0010, 3'd3, 2'd1, 3'd2}) begin
      failures++; $display("[TB] FAIL single_fields got=%h exp=%h", {s_AxADDR_o, s_AxLEN_o, s_AxBURST_o, s_AxSIZE_o}, {32'h4000_0010, 3'd3, 2'd1, 3'd2}); end
    checks++; if (outst_ctn_o !== 4'd1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=1", outst_ctn_o); end
    checks++; if ({ord_valid_o, ord_mst_id_o, ord_AxLEN_o} !== {1'b1, 1'b0, 3'd3}) begin
      failures++; $display("[TB] FAIL single_order got=%b exp=%b", {ord_valid_o, ord_mst_id_o, ord_AxLEN_o}, {1'b1, 1'b0, 3'd3}); end
    tick();
    #1;
    checks++; if (s_AxVALID_o !== 1'b0) begin failures++; $display("[TB] FAIL single_idle got=%b exp=0", s_AxVALID_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m_valid = 2'b11; m_id[0] = 5'h0A; m_id[1] = 5'h15; s_ready = 1'b1; ord_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (m_AxREADY_o !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++; $display("[TB] FAIL rr_grant[%0d] got=%b exp=%b", i, m_AxREADY_o, (i % 2 == 0) ? 2'b01 : 2'b10); end
      if (i > 0) begin
        checks++; if ({s_AxVALID_o, s_AxID_o[5]} !== {1'b1, 1'((i - 1) % 2)}) begin
          failures++; $display("[TB] FAIL rr_out[%0d] got=%b exp=%b", i, {s_AxVALID_o, s_AxID_o[5]}, {1'b1, 1'((i - 1) % 2)}); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_valid = 2'b01; m_addr[0] = 32'h1000_0000; m_id[0] = 5'h07; s_ready = 1'b0;
    #1;
    checks++; if (m_AxREADY_o !== 2'b01) begin failures++; $display("[TB] FAIL bp_first got=%b exp=01", m_AxREADY_o); end
    tick();
    m_valid = 2'b10; m_addr[1] = 32'h2000_0040; m_id[1] = 5'h11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({s_AxVALID_o, s_AxADDR_o, s_AxID_o, m_AxREADY_o} !== {1'b1, 32'h1000_0000, 6'h07, 2'b00}) begin
        failures++; $display("[TB] FAIL bp_hold[%0d] got=%h exp=%h", i, {s_AxVALID_o, s_AxADDR_o, s_AxID_o, m_AxREADY_o}, {1'b1, 32'h1000_0000, 6'h07, 2'b00}); end
      tick();
    end
    s_ready = 1'b1;
    #1;
    checks++; if (m_AxREADY_o !== 2'b10) begin failures++; $display("[TB] FAIL bp_handshake got=%b exp=10", m_AxREADY_o); end
    tick();
    m_valid = 2'b00;
    #1;
    checks++; if ({s_AxVALID_o, s_AxADDR_o, s_AxID_o} !== {1'b1, 32'h2000_0040, 6'h31}) begin
      failures++; $display("[TB] FAIL bp_next got=%h exp=%h", {s_AxVALID_o, s_AxADDR_o, s_AxID_o}, {1'b1, 32'h2000_0040, 6'h31}); end
  endtask

  task automatic test_full();
    do_reset();
    m_valid = 2'b01; m_len[0] = 3'd5; s_ready = 1'b1; ord_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (m_AxREADY_o !== 2'b01) begin failures++; $display("[TB] FAIL full_fill[%0d] got=%b exp=01", i, m_AxREADY_o); end
      tick();
    end
    #1;
    checks++; if ({outst_ctn_o, m_AxREADY_o} !== {4'd8, 2'b00}) begin
      failures++; $display("[TB] FAIL full_stall got=%h exp=%h", {outst_ctn_o, m_AxREADY_o}, {4'd8, 2'b00}); end
    ord_ready = 1'b1;
    #1;
    checks++; if (m_AxREADY_o !== 2'b00) begin failures++; $display("[TB] FAIL full_samecycle_pop got=%b exp=00", m_AxREADY_o); end
    tick();
    ord_ready = 1'b0;
    #1;
    checks++; if ({outst_ctn_o, m_AxREADY_o} !== {4'd7, 2'b01}) begin
      failures++; $display("[TB] FAIL full_after_pop got=%h exp=%h", {outst_ctn_o, m_AxREADY_o}, {4'd7, 2'b01}); end
    tick();
    m_valid = 2'b00;
    #1;
    checks++; if (outst_ctn_o !== 4'd8) begin failures++; $display("[TB] FAIL full_refill got=%0d exp=8", outst_ctn_o); end
  endtask

  task automatic test_push_pop();
    do_reset();
    m_valid = 2'b11; m_len[0] = 3'($urandom_range(0, 7)); m_len[1] = 3'($urandom_range(0, 7));
    s_ready = 1'b1; ord_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (last_acc >= 0) m_len[last_acc] = 3'($urandom_range(0, 7));
    end
    #1;
    checks++; if (outst_ctn_o !== 4'd3) begin failures++; $display("[TB] FAIL pp_before got=%0d exp=3", outst_ctn_o); end
    ord_ready = 1'b1;
    tick();
    m_valid = 2'b00;
    #1;
    checks++; if (outst_ctn_o !== 4'd3) begin failures++; $display("[TB] FAIL pp_same got=%0d exp=3", outst_ctn_o); end
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({ord_valid_o, ord_mst_id_o, ord_AxLEN_o} !== {1'b1, 1'((i + 1) % 2), ord_q[0][2:0]}) begin
        failures++; $display("[TB] FAIL pp_order[%0d] got=%b exp=%b", i, {ord_valid_o, ord_mst_id_o, ord_AxLEN_o}, {1'b1, 1'((i + 1) % 2), ord_q[0][2:0]}); end
      tick();
    end
    #1;
    checks++; if ({ord_valid_o, outst_ctn_o} !== 5'd0) begin failures++; $display("[TB] FAIL pp_drained got=%b exp=0", {ord_valid_o, outst_ctn_o}); end
  endtask

  task automatic test_async_reset();
    do_reset();
    m_valid = 2'b01; s_ready = 1'b1; ord_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    m_valid = 2'b00; s_ready = 1'b0;
    #1;
    checks++; if ({s_AxVALID_o, outst_ctn_o} !== {1'b1, 4'd5}) begin
      failures++; $display("[TB] FAIL areset_pre got=%h exp=%h", {s_AxVALID_o, outst_ctn_o}, {1'b1, 4'd5}); end
    #1;
    ARESET = 1'b1;
    #1;
    checks++; if ({s_AxVALID_o, outst_ctn_o, ord_valid_o} !== 6'd0) begin
      failures++; $display("[TB] FAIL areset_immediate got=%b exp=0", {s_AxVALID_o, outst_ctn_o, ord_valid_o}); end
    @(negedge ACLK);
    ARESET = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_valid[k] || last_acc == k) begin
          m_valid[k] = 1'($urandom_range(0, 1));
          m_id[k] = 5'($urandom); m_addr[k] = $urandom; m_burst[k] = 2'($urandom);
          m_len[k] = 3'($urandom); m_size[k] = 3'($urandom);
        end
      end
      s_ready = ($urandom_range(0, 3) != 0);
      ord_ready = ($urandom_range(0, 2) == 0);
      #1;
      model_eval();
      checks++; if (m_AxREADY_o !== e_ready) begin failures++; $display("[TB] FAIL rnd_mready[%0d] got=%b exp=%b", cyc, m_AxREADY_o, e_ready); end
      checks++; if (s_AxVALID_o !== e_busy) begin failures++; $display("[TB] FAIL rnd_svalid[%0d] got=%b exp=%b", cyc, s_AxVALID_o, e_busy); end
      if (e_busy) begin
        checks++; if ({s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o} !== {e_id, e_addr, e_burst, e_len, e_size}) begin
          failures++; $display("[TB] FAIL rnd_sfields[%0d] got=%h exp=%h", cyc, {s_AxID_o, s_AxADDR_o, s_AxBURST_o, s_AxLEN_o, s_AxSIZE_o}, {e_id, e_addr, e_burst, e_len, e_size}); end
      end
      checks++; if ({ord_valid_o, outst_ctn_o} !== {ord_q.size() > 0, 4'(ord_q.size())}) begin
        failures++; $display("[TB] FAIL rnd_count[%0d] got=%h exp=%h", cyc, {ord_valid_o, outst_ctn_o}, {ord_q.size() > 0, 4'(ord_q.size())}); end
      if (ord_q.size() > 0) begin
        checks++; if ({ord_mst_id_o, ord_AxLEN_o} !== ord_q[0]) begin
          failures++; $display("[TB] FAIL rnd_head[%0d] got=%h exp=%h", cyc, {ord_mst_id_o, ord_AxLEN_o}, ord_q[0]); end
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_full();
    test_push_pop();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
